bus_hold_launch: RTL

Source-domain launcher that feeds the destination-side three-stage bus synchroniser.
- Accepts words on a valid/ready interface and drives them onto a registered, glitch-free Bus_out.
- Guarantees every launched value stays stable for at least HOLD_CYCLES src_clk cycles, so the destination stability filter always sees it.
- Provides a 1-entry pending slot, with optional coalescing (newest wins) and a drop counter.

---
 rtl/bus_hold_launch_pkg.sv | 23 ++
 rtl/bus_hold_launch_if.sv | 15 +
 rtl/bus_hold_launch_sat_counter.sv | 23 ++
 rtl/bus_hold_launch.sv | 120 ++++++++++++
 4 files changed

// File: rtl/bus_hold_launch_pkg.sv
// Shared types and elaboration helpers for the source-side bus launcher.
`default_nettype none

package bus_launch_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // True when hold_cycles fits the hold counter and is non-zero.
  function automatic bit hold_cycles_legal(input int hold_cycles, input int hold_w);
    return (hold_cycles >= 1) && (hold_cycles <= (1 << hold_w) - 1);
  endfunction

  // ceil(4*t_dest/t_src)+2, periods in any common integer unit.
  function automatic int min_hold_cycles(input int t_dest, input int t_src);
    return (4 * t_dest + t_src - 1) / t_src + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_hold_launch_if.sv
// Valid/ready write channel into the bus launcher.
`default_nettype none

interface bus_hold_launch_if #(
  parameter int Bus_BW = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [Bus_BW-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

`default_nettype wire

// File: rtl/bus_hold_launch_sat_counter.sv
// Saturating up-counter with synchronous clear.
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_hold_launch.sv
// Launches words onto a registered bus and holds each for HOLD_CYCLES clocks,
// with a one-entry pending slot and optional newest-wins coalescing.
`default_nettype none

module bus_hold_launch
  import bus_launch_pkg::*;
#(
  parameter int Bus_BW      = 8,
  parameter int HOLD_CYCLES = 8,
  parameter int HOLD_W      = 8,
  parameter int COALESCE    = 0,
  parameter int DROP_W      = 8
) (
  input  logic              src_clk,
  input  logic              src_rst,
  bus_hold_launch_if.slave  wr,
  output logic [Bus_BW-1:0] Bus_out,
  output logic              busy,
  output logic              hold_done,
  output logic [DROP_W-1:0] drop_cnt
);

  if (!hold_cycles_legal(HOLD_CYCLES, HOLD_W)) begin : g_bad_hold
    $error("bus_hold_launch: HOLD_CYCLES out of range for HOLD_W");
  end

  localparam logic [HOLD_W-1:0] hold_load = HOLD_W'(HOLD_CYCLES - 1);

  state_t              state, state_next;
  logic [HOLD_W-1:0]   cnt, cnt_next;
  logic [Bus_BW-1:0]   bus_next;
  logic                pend_valid, pend_valid_next;
  logic [Bus_BW-1:0]   pend_data, pend_data_next;
  logic                drop_inc;
  logic                terminal;
  logic                accept;

  assign terminal = (state == HOLD) && (cnt == '0);
  assign accept   = wr.wr_valid && wr.wr_ready;

  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      Bus_out    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      Bus_out    <= bus_next;
      pend_valid <= pend_valid_next;
      pend_data  <= pend_data_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    bus_next        = Bus_out;
    pend_valid_next = pend_valid;
    pend_data_next  = pend_data;
    drop_inc        = 1'b0;
    case (state)
      IDLE: begin
        // A write equal to the bus is consumed without re-launching.
        if (accept && (wr.wr_data != Bus_out)) begin
          bus_next   = wr.wr_data;
          cnt_next   = hold_load;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!terminal) begin
          cnt_next = cnt - 1'b1;
          if (accept) begin
            pend_valid_next = 1'b1;
            pend_data_next  = wr.wr_data;
            drop_inc        = pend_valid;
          end
        end else if (pend_valid) begin
          bus_next        = pend_data;
          cnt_next        = hold_load;
          pend_valid_next = accept;
          if (accept) begin
            pend_data_next = wr.wr_data;
          end
        end else if (accept) begin
          // Bypass launches even an unchanged value to keep ordering simple.
          bus_next = wr.wr_data;
          cnt_next = hold_load;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr.wr_ready = 1'b1;
    if ((COALESCE == 0) && (state == HOLD) && !terminal) begin
      wr.wr_ready = ~pend_valid;
    end
    busy      = (state == HOLD) || pend_valid;
    hold_done = terminal;
  end

  sat_counter #(
    .W (DROP_W)
  ) u_drop_cnt (
    .clk   (src_clk),
    .clr   (src_rst),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

endmodule

`default_nettype wire
